// File: rtl/led_frame_scheduler.sv
// Round-robin scheduler sharing one WS2812 shifter between an animation (A) and override (B) source.
// Optional macro LED_REFRESH_EN: periodically re-sends the current frame after a long idle gap.
module led_frame_scheduler #(
    parameter int NUM_LEDS       = 6,
    parameter int LATCH_CYCLES   = 2400,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int REFRESH_CYCLES = 800000,
    localparam int FRAME_W       = 24 * NUM_LEDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_a,
    input  logic [FRAME_W-1:0] frame_a,
    output logic               ack_a,
    input  logic               req_b,
    input  logic [FRAME_W-1:0] frame_b,
    output logic               ack_b,
    output logic [FRAME_W-1:0] shift_frame,
    output logic               shift_start,
    input  logic               shift_done,
    output logic               busy,
    output logic               err,
    output logic [15:0]        frame_count
);

    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [LW-1:0] LATCH_LAST   = LW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_frame_q, shift_frame_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               shift_start_q, shift_start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               last_grant_q, last_grant_d;   // 1 = B was granted last
    logic [LW-1:0]      latch_cnt_q, latch_cnt_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               grant_a_s;
    logic               grant_b_s;
    logic               refresh_due_s;

    // A wins unless B also requests and A was the previous grantee.
    assign grant_a_s = req_a & (~req_b | last_grant_q);
    assign grant_b_s = req_b & ~grant_a_s;

`ifdef LED_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;

    assign refresh_due_s = (refresh_cnt_q == REFRESH_LAST);

    // Idle-time counter; restarts on every frame and whenever a source requests.
    always_comb begin
        refresh_cnt_d = '0;
        if ((state_q == ST_IDLE) && !(req_a || req_b)) begin
            if (refresh_due_s) begin
                refresh_cnt_d = '0;
            end else begin
                refresh_cnt_d = refresh_cnt_q + RW'(1);
            end
        end else begin
            refresh_cnt_d = '0;
        end
    end
`else
    assign refresh_due_s = 1'b0 && (REFRESH_CYCLES > 0);
`endif

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        shift_frame_d = shift_frame_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        shift_start_d = 1'b0;
        err_d         = err_q;
        frame_count_d = frame_count_q;
        last_grant_d  = last_grant_q;
        latch_cnt_d   = latch_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_a_s) begin
                    shift_frame_d = frame_a;
                    ack_a_d       = 1'b1;
                    last_grant_d  = 1'b0;
                    state_d       = ST_LOAD;
                end else if (grant_b_s) begin
                    shift_frame_d = frame_b;
                    ack_b_d       = 1'b1;
                    last_grant_d  = 1'b1;
                    state_d       = ST_LOAD;
                end else if (refresh_due_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shift_start_d = 1'b1;
                tmo_cnt_d     = '0;
                state_d       = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    frame_count_d = frame_count_q + 16'd1;
                    latch_cnt_d   = '0;
                    state_d       = ST_LATCH;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    err_d       = 1'b1;
                    latch_cnt_d = '0;
                    state_d     = ST_LATCH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == LATCH_LAST) begin
                    latch_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset darkens the strip and favours A on the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            shift_frame_q <= '0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            shift_start_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= 16'd0;
            last_grant_q  <= 1'b1;
            latch_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
`ifdef LED_REFRESH_EN
            refresh_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shift_frame_q <= shift_frame_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            shift_start_q <= shift_start_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
            last_grant_q  <= last_grant_d;
            latch_cnt_q   <= latch_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
`ifdef LED_REFRESH_EN
            refresh_cnt_q <= refresh_cnt_d;
`endif
        end
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign shift_frame = shift_frame_q;
    assign shift_start = shift_start_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: shifter model, ack scoreboard, vector table and corner sequences.
module tb_led_frame_scheduler;

    localparam int NL = 6;
    localparam int FW = 24 * NL;
    localparam int LC = 4;
    localparam int TC = 64;
    localparam int RC = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_a = 1'b0;
    logic          req_b = 1'b0;
    logic [FW-1:0] frame_a = '0;
    logic [FW-1:0] frame_b = '0;
    logic          shift_done = 1'b0;
    logic          ack_a, ack_b, shift_start, busy, err;
    logic [FW-1:0] shift_frame;
    logic [15:0]   frame_count;

    led_frame_scheduler #(
        .NUM_LEDS(NL), .LATCH_CYCLES(LC), .TIMEOUT_CYCLES(TC), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .frame_a(frame_a), .ack_a(ack_a),
        .req_b(req_b), .frame_b(frame_b), .ack_b(ack_b),
        .shift_frame(shift_frame), .shift_start(shift_start), .shift_done(shift_done),
        .busy(busy), .err(err), .frame_count(frame_count)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          src;
        logic [FW-1:0] frame;
    } exp_t;

    exp_t          exp_q[$];
    logic [FW-1:0] cur_frame = '0;
    int            ack_seen = 0;
    bit            model_en = 1'b1;

    // Scoreboard: each ack must match the next expected source/frame; frame must hold while busy.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            cur_frame = '0;
        end else if (ack_a || ack_b) begin
            check("ack_exclusive", FW'(ack_a & ack_b), FW'(0));
            if (exp_q.size() == 0) begin
                check("ack_unexpected", FW'(1), FW'(0));
            end else begin
                e = exp_q.pop_front();
                check("ack_src", FW'(ack_b), FW'(e.src));
                check("ack_frame", shift_frame, e.frame);
                cur_frame = e.frame;
            end
            ack_seen++;
        end else if (busy) begin
            check("frame_stable", shift_frame, cur_frame);
        end
    end

    // Shifter model: shift_done pulses 20 cycles after shift_start.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            shift_done = 1'b0;
            if (!rst) cnt = 0;
            else if (shift_start && model_en) cnt = 20;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) shift_done = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] rnd_frame();
        logic [FW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*24 +: 24] = 24'($urandom);
        return r;
    endfunction

    task automatic wait_ack(input string nm);
        int n;
        n = 0;
        while (!(ack_a || ack_b) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_int({nm, "_ack_seen"}, int'(ack_a || ack_b), 1);
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (!shift_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_int({nm, "_start_seen"}, int'(shift_start), 1);
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_busy"}, FW'(busy), FW'(0));
        check({nm, "_ack_a"}, FW'(ack_a), FW'(0));
        check({nm, "_ack_b"}, FW'(ack_b), FW'(0));
        check({nm, "_start"}, FW'(shift_start), FW'(0));
        check({nm, "_err"}, FW'(err), FW'(0));
        check({nm, "_count"}, FW'(frame_count), FW'(0));
        check({nm, "_frame"}, shift_frame, FW'(0));
    endtask

    typedef struct {
        logic          ra;
        logic          rb;
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic          src;
        int            cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int            n;
        int            base;
        bit            flag;
        logic [FW-1:0] f;
        logic [FW-1:0] last_frame;

        // Post-reset arbitration sequence: last_grant starts at B.
        tbl[0] = '{1'b1, 1'b1, rnd_frame(), rnd_frame(), 1'b0, 1};
        tbl[1] = '{1'b1, 1'b1, rnd_frame(), rnd_frame(), 1'b1, 2};
        tbl[2] = '{1'b0, 1'b1, rnd_frame(), rnd_frame(), 1'b1, 3};
        tbl[3] = '{1'b1, 1'b1, rnd_frame(), rnd_frame(), 1'b0, 4};
        tbl[4] = '{1'b1, 1'b0, rnd_frame(), rnd_frame(), 1'b0, 5};
        tbl[5] = '{1'b1, 1'b1, rnd_frame(), rnd_frame(), 1'b1, 6};
        last_frame = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        rst = 1'b1;
        @(negedge clk);

        // Single frame from A with the documented colour pattern.
        f = {{3{24'h00CEFF}}, {3{24'h7F32A8}}};
        frame_a = f;
        exp_q.push_back('{1'b0, f});
        req_a = 1'b1;
        @(negedge clk);
        check("t2_ack_a", FW'(ack_a), FW'(1));
        check("t2_frame", shift_frame, f);
        req_a = 1'b0;
        @(negedge clk);
        check("t2_start", FW'(shift_start), FW'(1));
        check("t2_ack_pulse", FW'(ack_a), FW'(0));
        @(negedge clk);
        check("t2_start_pulse", FW'(shift_start), FW'(0));
        n = 0;
        while (!shift_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("t2_done_seen", int'(shift_done), 1);
        wait_busy_low(n);
        check_int("t2_latch_len", n, LC);
        check_int("t2_count", int'(frame_count), 1);

        // Both sources held: B first (A won last), then strict alternation.
        frame_a = rnd_frame();
        frame_b = rnd_frame();
        exp_q.push_back('{1'b1, frame_b});
        exp_q.push_back('{1'b0, frame_a});
        exp_q.push_back('{1'b1, frame_b});
        exp_q.push_back('{1'b0, frame_a});
        base = ack_seen;
        req_a = 1'b1;
        req_b = 1'b1;
        n = 0;
        while (ack_seen < base + 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_int("t3_grants", ack_seen - base, 4);
        req_a = 1'b0;
        req_b = 1'b0;
        wait_busy_low(n);
        check_int("t3_count", int'(frame_count), 5);

        // B requests while A's frame is in flight and must wait for IDLE.
        frame_a = rnd_frame();
        exp_q.push_back('{1'b0, frame_a});
        req_a = 1'b1;
        wait_ack("t4a");
        req_a = 1'b0;
        wait_start("t4a");
        repeat (5) @(negedge clk);
        frame_b = rnd_frame();
        exp_q.push_back('{1'b1, frame_b});
        req_b = 1'b1;
        flag = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            if (ack_b) flag = 1'b1;
            @(negedge clk);
            n++;
        end
        check_int("t4_no_early_ack", int'(flag), 0);
        check_int("t4_idle_reached", int'(busy), 0);
        @(negedge clk);
        check("t4_ack_b", FW'(ack_b), FW'(1));
        req_b = 1'b0;
        wait_busy_low(n);
        check_int("t4_count", int'(frame_count), 7);

        // Shifter never answers: timeout after TC SHIFT cycles, err sticky, no count.
        model_en = 1'b0;
        frame_a = rnd_frame();
        exp_q.push_back('{1'b0, frame_a});
        req_a = 1'b1;
        wait_ack("t5");
        req_a = 1'b0;
        wait_start("t5");
        n = 0;
        while (!err && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_int("t5_shift_len", n, TC);
        check_int("t5_busy_latch", int'(busy), 1);
        wait_busy_low(n);
        check_int("t5_latch_rest", n, LC - 1);
        check_int("t5_count", int'(frame_count), 7);
        model_en = 1'b1;
        frame_a = rnd_frame();
        exp_q.push_back('{1'b0, frame_a});
        req_a = 1'b1;
        wait_ack("t5b");
        req_a = 1'b0;
        wait_busy_low(n);
        check_int("t5_err_sticky", int'(err), 1);
        check_int("t5b_count", int'(frame_count), 8);

        // Asynchronous reset in the middle of SHIFT.
        frame_a = rnd_frame();
        exp_q.push_back('{1'b0, frame_a});
        req_a = 1'b1;
        wait_ack("t1");
        req_a = 1'b0;
        wait_start("t1");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("t1_async");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t1_idle", FW'(busy), FW'(0));
        shift_done = 1'b1;
        @(negedge clk);
        shift_done = 1'b0;
        repeat (3) @(negedge clk);
        check_int("t1_done_ignored", int'(frame_count), 0);
        check_int("t1_still_idle", int'(busy), 0);

        // Vector table: arbitration from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            frame_a = tbl[i].fa;
            frame_b = tbl[i].fb;
            last_frame = tbl[i].src ? tbl[i].fb : tbl[i].fa;
            exp_q.push_back('{tbl[i].src, last_frame});
            req_a = tbl[i].ra;
            req_b = tbl[i].rb;
            wait_ack("tbl");
            check("tbl_src", FW'(ack_b), FW'(tbl[i].src));
            req_a = 1'b0;
            req_b = 1'b0;
            wait_busy_low(n);
            check_int("tbl_count", int'(frame_count), tbl[i].cnt);
        end

`ifdef LED_REFRESH_EN
        n = 0;
        while (!shift_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_int("t6_refresh_start", int'(shift_start), 1);
        check_int("t6_interval", int'(n >= RC - 5 && n <= RC + 10), 1);
        check("t6_frame", shift_frame, last_frame);
        wait_busy_low(n);
        check_int("t6_count", int'(frame_count), 7);
`else
        flag = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (shift_start) flag = 1'b1;
        end
        check_int("t6_no_refresh", int'(flag), 0);
        check_int("t6_count", int'(frame_count), 6);
        check("t6_frame_kept", shift_frame, last_frame);
`endif
        check_int("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
